// File: rtl/disp_pkg.sv
// Shared constants and digit-selection helper for the multiplexed BCD display scanner.
// The blank code matches the downstream seven-segment decoder's all-segments-off default.
package disp_pkg;

   localparam int unsigned N_DIGITS = 4;
   localparam int unsigned DATA_W   = 4 * N_DIGITS;
   localparam int unsigned SLOT_W   = $clog2(N_DIGITS);

   localparam logic [3:0]          BLANK_CODE = 4'hF;
   localparam logic [N_DIGITS-1:0] AN_OFF     = 4'b1111;

   typedef logic [SLOT_W-1:0] slot_t;

   // Code presented for one scan slot; a digit is a leading zero only if it and
   // every more-significant digit are zero. Digit 0 is always shown.
   function automatic logic [3:0] slot_code(input logic [DATA_W-1:0] value,
                                            input slot_t             slot,
                                            input logic              blank_lz);
      logic [3:0] nib;
      logic       lead_zero;
      nib = value[{slot, 2'b00} +: 4];
      unique case (slot)
         2'd3:    lead_zero = (value[15:12] == 4'h0);
         2'd2:    lead_zero = (value[15:8] == 8'h00);
         2'd1:    lead_zero = (value[15:4] == 12'h000);
         default: lead_zero = 1'b0;
      endcase
      return (blank_lz && lead_zero) ? BLANK_CODE : nib;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler for the display scan: pulses tick for one cycle every
// PRESCALE clocks, on the cycle where the counter sits at its terminal value.
module scan_tick_gen #(
   parameter int unsigned PRESCALE = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bcd_scan_driver.sv
// Four-digit multiplexed display scanner: double-buffered packed-BCD value, one digit per
// scan slot on digit_code with matching active-low enable, optional leading-zero blanking.
module bcd_scan_driver
   import disp_pkg::*;
#(
   parameter int unsigned PRESCALE = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [DATA_W-1:0]   load_data,
   input  logic                blank_lz,
   output logic [3:0]          digit_code,
   output logic [N_DIGITS-1:0] an_n
);

   logic                tick;
   logic                frame_end;
   logic                accept;

   logic [DATA_W-1:0]   display_q, display_d;
   logic [DATA_W-1:0]   pending_q, pending_d;
   logic                pending_full_q, pending_full_d;
   slot_t               idx_q, idx_d;
   logic [3:0]          code_q, code_d;
   logic [N_DIGITS-1:0] an_q, an_d;

   scan_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   always_comb begin
      display_d      = display_q;
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      idx_d          = tick ? idx_q + slot_t'(1) : idx_q;

      frame_end = tick && (idx_q == slot_t'(N_DIGITS - 1));
      accept    = load_valid && !pending_full_q;

      // accept needs an empty buffer and commit needs a full one, so they never collide
      if (accept) begin
         pending_d      = load_data;
         pending_full_d = 1'b1;
      end else if (frame_end && pending_full_q) begin
         display_d      = pending_q;
         pending_full_d = 1'b0;
      end

      // Outputs follow next-state so the slot and new frame appear on the same edge
      an_d   = ~(N_DIGITS'(1) << idx_d);
      code_d = slot_code(display_d, idx_d, blank_lz);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         display_q      <= '0;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         idx_q          <= '0;
         code_q         <= BLANK_CODE;
         an_q           <= AN_OFF;
      end else begin
         display_q      <= display_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         idx_q          <= idx_d;
         code_q         <= code_d;
         an_q           <= an_d;
      end
   end

   assign load_ready = !pending_full_q;
   assign digit_code = code_q;
   assign an_n       = an_q;

endmodule

// File: doc/bcd_scan_driver.md
# bcd_scan_driver

Four-digit multiplexed display scanner that sits directly upstream of the BCD-to-seven-segment decoder. It holds a 16-bit packed-BCD value, presents one digit at a time on a 4-bit code bus that the decoder consumes, and drives active-low digit enables in lockstep. New values arrive over a valid/ready handshake and are double-buffered so a frame never shows mixed old and new digits. Optional leading-zero blanking emits the decoder's all-segments-off code.

## Interface
- PRESCALE, 50000: clock cycles each digit is enabled; legal range ≥ 2.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_valid  in  1  load_data is valid this cycle.
- load_ready  out  1  pending buffer empty; a load can be accepted.
- load_data  in  16  packed BCD, [15:12] = digit 3 (MSD), [3:0] = digit 0 (LSD).
- blank_lz  in  1  enable leading-zero blanking; sampled every cycle.
- digit_code  out  4  BCD code of the enabled digit, to the decoder; 4'hF = blank.
- an_n  out  4  digit enables, active-low; an_n[i] = 0 enables digit i.

## Operation
- Registers:
  - display (16 bit, reset 0)
  - pending (16 bit) with pending_full flag (reset 0)
  - scan index idx (2 bit, reset 0)
  - prescale counter cnt (0..PRESCALE-1, reset 0)
- Accept: a load is accepted on an edge where load_valid && load_ready; pending <= load_data and pending_full <= 1.
- load_ready = !pending_full, driven from a register with no combinational path from load_valid.
- Scan: cnt increments every cycle. When cnt == PRESCALE-1, cnt <= 0 and idx <= idx+1, so idx wraps 3→0.
- Frame boundary: the edge on which idx wraps 3→0.
  - If pending_full, display <= pending and pending_full <= 0 on that edge.
  - The digit 0 output on that edge already reflects the new display value.
- Simultaneous accept and boundary:
  - If pending is empty, the new data lands in pending and commits at the next frame boundary.
  - If pending is full, no accept is possible (load_ready = 0); load_ready rises on the commit edge.
- Outputs for slot idx = i:
  - an_n = ~(4'b0001 << i).
  - digit_code = display[4i+3:4i], unless the digit is blanked.
- Blanking (blank_lz = 1):
  - Digit 3 is blanked if d3 == 0.
  - Digit 2 is blanked if d3 == d2 == 0.
  - Digit 1 is blanked if d3 == d2 == d1 == 0.
  - Digit 0 is never blanked.
  - A blanked digit outputs digit_code = 4'hF; an_n stays asserted.
- Non-BCD nibbles (A–F) pass through unchanged; the decoder renders them blank.

## Timing
- Reset (asynchronous, immediate):
  - an_n = 4'b1111, digit_code = 4'hF, load_ready = 1.
  - display = 0, pending discarded, idx = 0, cnt = 0.
- First rising edge after rst_n deasserts: an_n = 4'b1110, digit_code = display[3:0].
- Each digit is then held for exactly PRESCALE cycles; a full frame is 4*PRESCALE cycles.
- an_n and digit_code are registered and change on the same edge. There is never a cycle with two enables low.
- load_ready falls on the accept edge and rises on the commit edge.
- Worst-case load-to-display latency is 4*PRESCALE+1 cycles after pending frees.
- rst_n asserted mid-frame or with pending full returns all state to reset values; the pending load is lost.

## Structure
- Shared package disp_pkg holds:
  - N_DIGITS = 4
  - BLANK_CODE = 4'hF (matches the decoder's default, all-off)
  - AN_OFF = 4'b1111
- Sub-module scan_tick_gen (parameter PRESCALE): owns cnt and outputs a one-cycle tick when cnt == PRESCALE-1.
- The top module holds idx, the buffers, blanking and the output registers.
- Expected size: about 150–250 lines total.

## Test plan
All scenarios use PRESCALE = 4.
- **Reset:** hold rst_n low for 3 cycles → an_n = 1111, digit_code = F, load_ready = 1. First edge after release → an_n = 1110, digit_code = 0.
- **Load and scan:** load 16'h1234 in frame 0 → from the next frame boundary, digit_code sequence is 4,3,2,1 with an_n 1110,1101,1011,0111, each held for 4 cycles.
- **Back-pressure:**
  - Load 16'h5678, then hold load_valid with 16'h9999 → load_ready = 0 until the boundary edge. 5678 displays for one frame, then 9999 is accepted and displays in the following frame.
  - No frame ever shows mixed digits.
- **Leading-zero blanking:** blank_lz = 1, load 16'h0070 → digits 0..3 show 0,7,F,F. Load 16'h0000 → 0,F,F,F. Set blank_lz = 0 → 0,0,0,0.
- **Accept on boundary edge:** assert load_valid (16'h4321) exactly on the 3→0 edge with pending empty → the current frame keeps the old value and 4321 commits at the next boundary.
- **Mid-frame reset:** assert rst_n mid-slot with pending full → outputs go to reset values asynchronously. After release the display shows 0000 and load_ready = 1.
